hex_str_ctrl: RTL
=================

// Module: hex_str_ctrl
// PURPOSE
//  Sequences the hex_ch glyph generator to render a DIGITS-wide hex word as a raster pixel stream.
//  Latches a value on start and walks rows 0..2^CH_ROW_W-1. Within each row it walks digits MSB
//  first and issues CH_COL_N pixel reads per digit.
//  Inserts GAP_PX blank columns between digits. Emits the pixels on a valid/ready stream towards
//  the display/USB packer, with end-of-line and end-of-frame tags.
// PARAMETERS
//  CH_W        4   hex_ch character select width
//  CH_ROW_W    3   hex_ch row select width (2^CH_ROW_W rows per glyph)
//  CH_COL_N    8   pixels per glyph row (reads per digit per row)
//  DIGITS      4   hex digits rendered; value width = 4*DIGITS
//  GAP_PX      1   blank (0) pixels between adjacent digits; 0 = none
//  FIFO_DEPTH  4   output buffer entries (power of 2, >= hex_ch read latency + 1)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous active-high reset
//  start        in   1           1-cycle request; ignored while busy
//  value        in   4*DIGITS    word to render; sampled only when start is accepted
//  busy         out  1           high from the cycle after accepted start until done
//  done         out  1           1-cycle pulse when the final pixel is accepted downstream
//  ch_sel       out  CH_W        to hex_ch: digit nibble
//  row_sel      out  CH_ROW_W    to hex_ch: glyph row
//  ch_px_rd     out  1           to hex_ch: pixel read strobe
//  ch_px_valid  in   1           from hex_ch: returned pixel valid
//  ch_px_in     in   1           from hex_ch: returned pixel value
//  px_out       out  1           stream pixel (1 = lit)
//  px_eol       out  1           qualifies px_out: last pixel of a row
//  px_eof       out  1           qualifies px_out: last pixel of the frame
//  px_valid     out  1           stream valid
//  px_ready     in   1           stream ready; a transfer occurs when px_valid & px_ready
// BEHAVIOUR
//  Reset values: all outputs 0. FSM returns to IDLE, FIFO is flushed, the in-flight counter is cleared.
//  hex_ch contract: each ch_px_rd cycle returns exactly one ch_px_valid, in order, after a fixed latency.
//  hex_ch advances its column on every read and wraps after CH_COL_N reads.
//  ch_sel/row_sel are held stable for all CH_COL_N reads of one digit.
//  Credit rule: ch_px_rd may assert only when fifo_count + inflight < FIFO_DEPTH.
//  inflight increments on rd, decrements on valid; both in the same cycle -> unchanged.
//  Returned pixels push {px, eol, eof}. Tags are computed at issue time and carried in a
//  tag shift alongside inflight.
//  FSM states:
//   IDLE  -> ISSUE on start. Latch value, row=0, dig=DIGITS-1, col=0, busy=1.
//   ISSUE: rd when credit allows, col++. On col==CH_COL_N-1 with rd:
//          if dig!=0 and GAP_PX>0 -> GAP; elif dig!=0 -> ISSUE with dig--; else NEXTROW.
//   GAP  : wait until inflight==0, then push GAP_PX zero pixels (eol=0) as FIFO space allows.
//          Then dig-- -> ISSUE.
//   NEXTROW: row==max -> DRAIN, else row++, dig=DIGITS-1 -> ISSUE.
//   DRAIN: wait until inflight==0 and FIFO empty -> IDLE, done=1 for 1 cycle, busy=0.
//  Row length = DIGITS*CH_COL_N + (DIGITS-1)*GAP_PX pixels. The last pixel of a row has eol=1
//  (no trailing gap). eof=1 only on the last pixel of the last row, which also carries eol=1.
//  Backpressure: px_ready low stalls the stream. Credit throttling stops reads with no pixel loss.
//  FIFO full and pop in the same cycle allows a push.
//  px_valid = FIFO not empty. Stream output is registered; first pixel appears at hex_ch latency + 1
//  cycles after the first rd.
//  start during busy: ignored, value not resampled. start in the same cycle as done: accepted.
//  rst mid-frame: immediate abort, no done pulse. Pixels still returning from hex_ch are discarded,
//  because hex_ch shares rst.
//  Digit index: ch_sel = value[4*dig +: 4]. CH_W > 4 zero-extends the nibble.
// STRUCTURE
//  hex_pkg: FSM state encoding, the glyph-dimension localparams derived from CH_ROW_W/CH_COL_N,
//  and the FIFO entry struct {px, eol, eof}.
//  One sub-module: hex_px_fifo, a sync FIFO of FIFO_DEPTH x 3 bits with count output.
//  The counters, credit logic and FSM stay in hex_str_ctrl.
// TESTING
//  1. value=16'hA7F0, start, px_ready=1 -> 8 rows x 35 px. Each row equals the golden glyphs
//     A,7,F,0 with 1-px gaps. 8 eol pulses, 1 eof, done exactly once.
//  2. Same frame, px_ready toggling 1-of-3 random -> pixel sequence identical to test 1.
//     inflight+fifo_count never exceeds 4; no px_out change while valid & !ready.
//  3. px_ready=0 for 50 cycles after start -> ch_px_rd asserts at most 4 times, then stays low
//     until ready returns.
//  4. start with value=16'h1234, then start with 16'hFFFF at cycle 10 -> second start ignored;
//     rendered frame is 1,2,3,4.
//  5. rst asserted during row 3 -> next cycle: all outputs 0, busy=0, no done.
//     A new start with 16'h0000 renders a clean full frame.
//  6. GAP_PX=0, DIGITS=2, value=8'hBC -> rows of 16 px; eol on pixel 15; frame total 128 px.

Source files
------------

// File: rtl/hex_str_ctrl_pkg.sv
// Shared types and helpers for the hex string renderer: FSM encoding,
// FIFO entry layout and glyph-dimension defaults.
package hex_str_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_GAP     = 3'd2,
        ST_NEXTROW = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    // One buffered stream pixel with its row/frame tags.
    typedef struct packed {
        logic px;
        logic eol;
        logic eof;
    } px_ent_t;

    // Default glyph geometry of the hex_ch generator.
    localparam int unsigned DEF_CH_ROW_W = 32'd3;
    localparam int unsigned DEF_CH_COL_N = 32'd8;

    // Number of glyph rows for a given row-select width.
    function automatic int unsigned glyph_rows(input int unsigned row_w);
        return 32'd1 << row_w;
    endfunction

    // Index width for a counter walking 0..n-1 (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/hex_str_ctrl_if.sv
// Pixel stream (valid/ready) between the renderer and the display packer.
interface hex_str_ctrl_if;
    logic px_out;
    logic px_eol;
    logic px_eof;
    logic px_valid;
    logic px_ready;

    modport master (output px_out, output px_eol, output px_eof, output px_valid, input px_ready);
    modport slave  (input px_out, input px_eol, input px_eof, input px_valid, output px_ready);
endinterface

// File: rtl/hex_str_ctrl_px_fifo.sv
// Small synchronous FIFO holding tagged stream pixels; output taken
// straight from the storage registers, not-empty flag registered.
module hex_str_ctrl_px_fifo
    import hex_str_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  px_ent_t                    din_i,
    input  logic                       pop_i,
    output px_ent_t                    dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       not_empty_o
);
    localparam int unsigned PTR_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 32'd1;

    px_ent_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ne_q;

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '{px: 1'b0, eol: 1'b0, eof: 1'b0};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ne_q     <= 1'b0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ne_q    <= (count_d != {CNT_W{1'b0}});
        end
    end

    assign dout_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign not_empty_o = ne_q;

endmodule

// File: rtl/hex_str_ctrl.sv
// Sequences a hex_ch glyph generator to raster a DIGITS-wide hex word
// into a tagged pixel stream. Reads are credit-limited so that every
// pixel already requested always has a FIFO slot waiting for it.
module hex_str_ctrl
    import hex_str_ctrl_pkg::*;
#(
    parameter int unsigned CH_W       = 32'd4,
    parameter int unsigned CH_ROW_W   = DEF_CH_ROW_W,
    parameter int unsigned CH_COL_N   = DEF_CH_COL_N,
    parameter int unsigned DIGITS     = 32'd4,
    parameter int unsigned GAP_PX     = 32'd1,
    parameter int unsigned FIFO_DEPTH = 32'd4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CH_W-1:0]       ch_sel_o,
    output logic [CH_ROW_W-1:0]   row_sel_o,
    output logic                  ch_px_rd_o,
    input  logic                  ch_px_valid_i,
    input  logic                  ch_px_in_i,
    hex_str_ctrl_if.master        px_if
);
    localparam int unsigned ROWS  = glyph_rows(CH_ROW_W);
    localparam int unsigned COL_W = idx_w(CH_COL_N);
    localparam int unsigned DIG_W = idx_w(DIGITS);
    localparam int unsigned GAP_W = idx_w(GAP_PX);
    localparam int unsigned PTR_W = idx_w(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 32'd1;

    state_e               state_q;
    logic [4*DIGITS-1:0]  value_q;
    logic [CH_ROW_W-1:0]  row_q;
    logic [DIG_W-1:0]     dig_q;
    logic [COL_W-1:0]     col_q;
    logic [GAP_W-1:0]     gap_q;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_d;
    logic [1:0]           tag_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     tag_wr_q;
    logic [PTR_W-1:0]     tag_rd_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_q;
    logic [CH_W-1:0]      ch_sel_q;
    logic [CH_ROW_W-1:0]  row_sel_q;

    logic [CNT_W-1:0]     fifo_cnt_s;
    logic                 fifo_ne_s;
    px_ent_t              fifo_dout_s;
    px_ent_t              fifo_din_s;
    logic                 fifo_push_s;
    logic                 pop_s;
    logic                 credit_s;
    logic                 issue_s;
    logic                 gap_push_s;
    logic                 last_col_s;
    logic                 last_dig_s;
    logic                 last_row_s;
    logic                 tag_eol_s;
    logic                 tag_eof_s;
    logic                 empty_next_s;
    logic [3:0]           nib_s;

    assign pop_s        = fifo_ne_s & px_if.px_ready;
    assign credit_s     = ({1'b0, fifo_cnt_s} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue_s      = (state_q == ST_ISSUE) && credit_s;
    assign gap_push_s   = (state_q == ST_GAP) && (inflight_q == {CNT_W{1'b0}}) &&
                          ((fifo_cnt_s < CNT_W'(FIFO_DEPTH)) || pop_s);
    assign last_col_s   = (col_q == COL_W'(CH_COL_N - 32'd1));
    assign last_dig_s   = (dig_q == {DIG_W{1'b0}});
    assign last_row_s   = (row_q == CH_ROW_W'(ROWS - 32'd1));
    assign tag_eol_s    = last_col_s && last_dig_s;
    assign tag_eof_s    = tag_eol_s && last_row_s;
    assign empty_next_s = (fifo_cnt_s == {CNT_W{1'b0}}) || ((fifo_cnt_s == CNT_W'(1)) && pop_s);
    assign nib_s        = value_q[{dig_q, 2'b00} +: 4];
    assign fifo_push_s  = ch_px_valid_i | gap_push_s;

    // Returned glyph pixels take the tags recorded at issue; gap pixels are blank and untagged.
    always_comb begin
        fifo_din_s = '{px: 1'b0, eol: 1'b0, eof: 1'b0};
        if (ch_px_valid_i) begin
            fifo_din_s.px  = ch_px_in_i;
            fifo_din_s.eol = tag_q[tag_rd_q][1];
            fifo_din_s.eof = tag_q[tag_rd_q][0];
        end else begin
            fifo_din_s = '{px: 1'b0, eol: 1'b0, eof: 1'b0};
        end
    end

    // Reads outstanding at hex_ch; issue and return in one cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue_s, ch_px_valid_i})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Main sequencer: walks row / digit / column, issues reads, inserts gaps, drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            value_q    <= {(4*DIGITS){1'b0}};
            row_q      <= {CH_ROW_W{1'b0}};
            dig_q      <= {DIG_W{1'b0}};
            col_q      <= {COL_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            inflight_q <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                tag_q[i] <= 2'b00;
            end
            tag_wr_q   <= {PTR_W{1'b0}};
            tag_rd_q   <= {PTR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            ch_sel_q   <= {CH_W{1'b0}};
            row_sel_q  <= {CH_ROW_W{1'b0}};
        end else begin
            done_q     <= 1'b0;
            rd_q       <= issue_s;
            inflight_q <= inflight_d;
            if (issue_s) begin
                tag_q[tag_wr_q] <= {tag_eol_s, tag_eof_s};
                tag_wr_q        <= tag_wr_q + PTR_W'(1);
                ch_sel_q        <= CH_W'(nib_s);
                row_sel_q       <= row_q;
            end
            if (ch_px_valid_i) begin
                tag_rd_q <= tag_rd_q + PTR_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        value_q <= value_i;
                        row_q   <= {CH_ROW_W{1'b0}};
                        dig_q   <= DIG_W'(DIGITS - 32'd1);
                        col_q   <= {COL_W{1'b0}};
                        gap_q   <= {GAP_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        if (last_col_s) begin
                            col_q <= {COL_W{1'b0}};
                            if (!last_dig_s && (GAP_PX > 32'd0)) begin
                                state_q <= ST_GAP;
                            end else if (!last_dig_s) begin
                                dig_q <= dig_q - DIG_W'(1);
                            end else begin
                                state_q <= ST_NEXTROW;
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_push_s) begin
                        if (gap_q == GAP_W'(GAP_PX - 32'd1)) begin
                            gap_q   <= {GAP_W{1'b0}};
                            dig_q   <= dig_q - DIG_W'(1);
                            state_q <= ST_ISSUE;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                end
                ST_NEXTROW: begin
                    if (last_row_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        row_q   <= row_q + CH_ROW_W'(1);
                        dig_q   <= DIG_W'(DIGITS - 32'd1);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_q == {CNT_W{1'b0}}) && empty_next_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    hex_str_ctrl_px_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push_s),
        .din_i       (fifo_din_s),
        .pop_i       (pop_s),
        .dout_o      (fifo_dout_s),
        .count_o     (fifo_cnt_s),
        .not_empty_o (fifo_ne_s)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ch_sel_o       = ch_sel_q;
    assign row_sel_o      = row_sel_q;
    assign ch_px_rd_o     = rd_q;
    assign px_if.px_out   = fifo_dout_s.px;
    assign px_if.px_eol   = fifo_dout_s.eol;
    assign px_if.px_eof   = fifo_dout_s.eof;
    assign px_if.px_valid = fifo_ne_s;

endmodule
